// File: rtl/rv_pkg.sv
// Shared RV32 pipeline constants and types used by the writeback stage.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bundle plus the decode-side read ports of the register file.
interface wb_regfile_if
  import rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int WB_CNT_W = 32
);

  logic                RegWriteW;
  logic [1:0]          ResultSrcW;
  logic [XLEN-1:0]     ALUResultW;
  logic [XLEN-1:0]     ReadDataW;
  reg_idx_t            RdW;
  logic [XLEN-1:0]     PCPlus4W;
  reg_idx_t            Rs1D;
  reg_idx_t            Rs2D;
  logic [XLEN-1:0]     RD1D;
  logic [XLEN-1:0]     RD2D;
  logic [XLEN-1:0]     ResultW;
  logic [WB_CNT_W-1:0] WbCount;

  modport master (
    output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, Rs1D, Rs2D,
    input  RD1D, RD2D, ResultW, WbCount
  );

  modport slave (
    input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, Rs1D, Rs2D,
    output RD1D, RD2D, ResultW, WbCount
  );

endinterface

// File: rtl/wb_regfile_result_mux.sv
// Writeback result select; the reserved encoding yields zero so a write with it commits 0.
module wb_result_mux
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] read_data,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] result
);

  // Select the value to be written back
  always_comb begin
    result = {XLEN{1'b0}};
    case (sel)
      RESULT_ALU: result = alu_result;
      RESULT_MEM: result = read_data;
      RESULT_PC4: result = pc_plus4;
      default:    result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: commits ResultW into the integer register file, serves two
// write-first bypassed read ports and counts committed non-x0 writes.
module wb_regfile
  import rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int WB_CNT_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  wb_regfile_if.slave bus
);

  logic [XLEN-1:0]     regs_r [0:NREGS-1];
  logic [WB_CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]     result_s;
  logic                commit_s;
  logic [XLEN-1:0]     rd1_s;
  logic [XLEN-1:0]     rd2_s;

  wb_result_mux #(.XLEN(XLEN)) u_result_mux (
    .sel        (bus.ResultSrcW),
    .alu_result (bus.ALUResultW),
    .read_data  (bus.ReadDataW),
    .pc_plus4   (bus.PCPlus4W),
    .result     (result_s)
  );

  // Reset suppresses the commit, which also disables the bypass path
  assign commit_s = rst_n && bus.RegWriteW && (bus.RdW != 5'd0);

  // Register array and committed-write counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      cnt_r <= {WB_CNT_W{1'b0}};
    end else if (commit_s) begin
      regs_r[bus.RdW] <= result_s;
      cnt_r           <= cnt_r + {{(WB_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Read port 1: x0 hardwired, then write-first bypass, then array
  always_comb begin
    rd1_s = {XLEN{1'b0}};
    if (bus.Rs1D == 5'd0) begin
      rd1_s = {XLEN{1'b0}};
    end else if (commit_s && (bus.Rs1D == bus.RdW)) begin
      rd1_s = result_s;
    end else begin
      rd1_s = regs_r[bus.Rs1D];
    end
  end

  // Read port 2: resolved independently of port 1
  always_comb begin
    rd2_s = {XLEN{1'b0}};
    if (bus.Rs2D == 5'd0) begin
      rd2_s = {XLEN{1'b0}};
    end else if (commit_s && (bus.Rs2D == bus.RdW)) begin
      rd2_s = result_s;
    end else begin
      rd2_s = regs_r[bus.Rs2D];
    end
  end

  assign bus.RD1D    = rd1_s;
  assign bus.RD2D    = rd2_s;
  assign bus.ResultW = result_s;
  assign bus.WbCount = cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile; a 4-bit-counter instance shadows
// the main one so counter wrap is reachable in a few cycles.
module tb_wb_regfile;
  import rv_pkg::*;

  localparam int K_RD1 = 0;
  localparam int K_RD2 = 1;
  localparam int K_RES = 2;
  localparam int K_CNT = 3;
  localparam int K_SCNT = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wb_regfile_if #(.XLEN(32), .WB_CNT_W(32)) bus ();
  wb_regfile_if #(.XLEN(32), .WB_CNT_W(4))  sbus ();

  wb_regfile #(.XLEN(32), .NREGS(32), .WB_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  wb_regfile #(.XLEN(32), .NREGS(32), .WB_CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_RD1:   return bus.RD1D;
      K_RD2:   return bus.RD2D;
      K_RES:   return bus.ResultW;
      K_CNT:   return bus.WbCount;
      K_SCNT:  return {28'd0, sbus.WbCount};
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: compare every expectation that is due in the current cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = sample(e.kind);
      checks++;
      if (act === e.val) passes++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.val);
    end
  end

  task automatic expect_v(input int kind, input logic [31:0] val, input string name);
    q.push_back('{cyc, kind, val, name});
  endtask

  task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.RegWriteW  = we;  sbus.RegWriteW  = we;
    bus.ResultSrcW = src; sbus.ResultSrcW = src;
    bus.ALUResultW = alu; sbus.ALUResultW = alu;
    bus.ReadDataW  = mem; sbus.ReadDataW  = mem;
    bus.PCPlus4W   = pc4; sbus.PCPlus4W   = pc4;
    bus.RdW        = rd;  sbus.RdW        = rd;
    bus.Rs1D       = rs1; sbus.Rs1D       = rs1;
    bus.Rs2D       = rs2; sbus.Rs2D       = rs2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rnd;
  logic [31:0] src_val [3];
  logic [1:0]  src_sel [3];

  initial begin
    src_val[0] = 32'h0000_1234; src_sel[0] = 2'b00;
    src_val[1] = 32'hDEAD_BEEF; src_sel[1] = 2'b01;
    src_val[2] = 32'h0000_0104; src_sel[2] = 2'b10;
    rnd = $urandom() | 32'h0000_0001;

    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    step();
    step();
    rst_n = 1'b1;

    // Random write to x5, seen through the bypass
    drive(1'b1, 2'b00, rnd, 32'd0, 32'd0, 5'd5, 5'd5, 5'd0);
    expect_v(K_RD1, rnd, "x5_bypass");
    expect_v(K_CNT, 32'd0, "cnt_before_commit");
    step();
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    expect_v(K_RD1, rnd, "x5_stored");
    expect_v(K_CNT, 32'd1, "cnt_one");
    step();
    expect_v(K_RD1, 32'd0, "x5_in_reset");
    step();
    rst_n = 1'b1;
    expect_v(K_RD1, 32'd0, "x5_after_reset");
    expect_v(K_CNT, 32'd0, "cnt_after_reset");
    step();

    // Source selection into x3, read back on port 2 a cycle later
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, src_sel[i],
            (i == 0) ? src_val[0] : 32'h1111_1111,
            (i == 1) ? src_val[1] : 32'h2222_2222,
            (i == 2) ? src_val[2] : 32'h3333_3333, 5'd3, 5'd0, 5'd0);
      expect_v(K_RES, src_val[i], "resultw_sel");
      step();
      drive(1'b0, 2'b00, 32'h9999_9999, 32'd0, 32'd0, 5'd3, 5'd0, 5'd3);
      expect_v(K_RD2, src_val[i], "x3_sel_readback");
      step();
    end

    // Reserved select still commits zero
    drive(1'b1, 2'b00, 32'h0000_0077, 32'd0, 32'd0, 5'd4, 5'd0, 5'd0);
    step();
    drive(1'b1, 2'b11, 32'h0000_0077, 32'h88, 32'h99, 5'd4, 5'd4, 5'd0);
    expect_v(K_RES, 32'd0, "resultw_reserved");
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd0);
    expect_v(K_RD1, 32'd0, "x4_reserved_zero");
    expect_v(K_CNT, 32'd5, "cnt_five");
    step();

    // Bypass on x7: no bypass when RegWriteW=0, both ports when it is set
    drive(1'b1, 2'b00, 32'h0000_1111, 32'd0, 32'd0, 5'd7, 5'd0, 5'd0);
    step();
    drive(1'b0, 2'b00, 32'h0000_A5A5, 32'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    expect_v(K_RD1, 32'h0000_1111, "x7_no_bypass_p1");
    expect_v(K_RD2, 32'h0000_1111, "x7_no_bypass_p2");
    step();
    drive(1'b1, 2'b00, 32'h0000_A5A5, 32'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    expect_v(K_RD1, 32'h0000_A5A5, "x7_bypass_p1");
    expect_v(K_RD2, 32'h0000_A5A5, "x7_bypass_p2");
    step();
    drive(1'b1, 2'b00, 32'h0000_5A5A, 32'd0, 32'd0, 5'd7, 5'd7, 5'd3);
    expect_v(K_RD1, 32'h0000_5A5A, "mixed_bypass_p1");
    expect_v(K_RD2, 32'h0000_0104, "mixed_stored_p2");
    step();

    // x0 guard
    drive(1'b1, 2'b00, 32'h0000_FFFF, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7);
    expect_v(K_RD1, 32'd0, "x0_same_cycle");
    expect_v(K_RD2, 32'h0000_5A5A, "x7_array");
    expect_v(K_CNT, 32'd8, "cnt_before_x0");
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    expect_v(K_RD1, 32'd0, "x0_next_cycle");
    expect_v(K_CNT, 32'd8, "cnt_after_x0");
    step();

    // Counter: three commits plus an x0 write, then wrap the 4-bit shadow
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'b00, 32'(i), 32'd0, 32'd0, (i == 4) ? 5'd0 : 5'(i), 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    expect_v(K_CNT, 32'd3, "cnt_three");
    expect_v(K_SCNT, 32'd3, "small_cnt_three");
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 2'b00, 32'd1, 32'd0, 32'd0, 5'd10, 5'd0, 5'd0);
      step();
    end
    drive(1'b1, 2'b00, 32'd2, 32'd0, 32'd0, 5'd10, 5'd0, 5'd0);
    expect_v(K_SCNT, 32'd15, "small_cnt_max");
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    expect_v(K_SCNT, 32'd0, "small_cnt_wrap");
    expect_v(K_CNT, 32'd16, "cnt_sixteen");
    step();

    // Reset mid-write: x9 holds 0x33, write of 0x55 presented under reset
    drive(1'b1, 2'b00, 32'h0000_0033, 32'd0, 32'd0, 5'd9, 5'd0, 5'd0);
    step();
    rst_n = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0055, 32'd0, 32'd0, 5'd9, 5'd9, 5'd9);
    expect_v(K_RD1, 32'h0000_0033, "no_bypass_in_reset_p1");
    expect_v(K_RD2, 32'h0000_0033, "no_bypass_in_reset_p2");
    expect_v(K_RES, 32'h0000_0055, "resultw_in_reset");
    step();
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd0);
    expect_v(K_RD1, 32'd0, "x9_discarded");
    expect_v(K_CNT, 32'd0, "cnt_reset_mid_write");
    step();

    step();
    step();
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
